fsk_bit_sync: RTL and testbench

Bit-timing recovery and byte framing stage that sits directly downstream of `demodulation`. It consumes the raw 1-bit `fsk_demod` decision stream, which is glitchy near symbol boundaries. It recovers bit timing with a glitch filter and an edge-resynchronised phase counter, hunts for a sync byte, and emits payload bytes with one-cycle strobes for the receive controller.

---
 rtl/fsk_bit_sync.sv | 194 +++++++++++++++++++
 tb/tb_fsk_bit_sync.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_bit_sync.sv
// fsk_bit_sync: glitch filter, edge-resynchronised bit clock and
// sync-word byte framer for the raw FSK demodulator decision stream.
module fsk_bit_sync #(
    parameter int         BIT_LEN     = 800,
    parameter int         FILT        = 4,
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FRAME_BYTES = 4,
    parameter int         MAX_RUN     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fsk_demod,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       locked,
    output logic       frame_err
);

    localparam int PW  = $clog2(BIT_LEN);
    localparam int SW  = $clog2(FILT + 1);
    localparam int RW  = $clog2(MAX_RUN + 1);
    localparam int BCW = $clog2(FRAME_BYTES + 1);

    localparam logic [PW-1:0]  PH_HALF   = PW'(BIT_LEN / 2);
    localparam logic [PW-1:0]  PH_LAST   = PW'(BIT_LEN - 1);
    localparam logic [SW-1:0]  STAB_LAST = SW'(FILT - 1);
    localparam logic [RW-1:0]  RUN_MAX   = RW'(MAX_RUN);
    localparam logic [BCW-1:0] FB_LAST   = BCW'(FRAME_BYTES - 1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic           r_s1;
    logic           r_s2;
    logic           r_lvl;
    logic [SW-1:0]  r_stab_cnt;
    logic [PW-1:0]  r_phase;
    logic [RW-1:0]  r_run_cnt;
    logic           r_bit_out;
    logic           r_bit_valid;
    logic [0:0]     r_state;
    // Seven bits of history suffice; the eighth is the incoming bit.
    logic [6:0]     r_sr;
    logic [6:0]     r_acc;
    logic [2:0]     r_bit_cnt;
    logic [BCW-1:0] r_byte_cnt;
    logic [7:0]     r_byte_out;
    logic           r_byte_valid;
    logic           r_frame_err;

    logic       w_mis;
    logic       w_lvl_chg;
    logic       w_wrap;
    logic [7:0] w_sr_next;
    logic [7:0] w_acc_next;
    logic       w_byte_done;
    logic       w_last_byte;
    logic       w_timeout;

    assign w_mis       = (r_s2 != r_lvl);
    assign w_lvl_chg   = w_mis && (r_stab_cnt == STAB_LAST);
    assign w_wrap      = (r_phase == PH_LAST) && !w_lvl_chg;
    assign w_sr_next   = {r_sr, r_bit_out};
    assign w_acc_next  = {r_acc, r_bit_out};
    assign w_byte_done = r_bit_valid && (r_bit_cnt == 3'd7);
    assign w_last_byte = w_byte_done && (r_byte_cnt == FB_LAST);
    assign w_timeout   = (r_run_cnt == RUN_MAX);

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign locked     = (r_state == ST_LOCK);
    assign frame_err  = r_frame_err;

    // Two-flop synchroniser for the asynchronous demod decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= fsk_demod;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after FILT consecutive mismatching clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lvl      <= 1'b0;
            r_stab_cnt <= '0;
        end else if (!w_mis) begin
            r_stab_cnt <= '0;
        end else if (w_lvl_chg) begin
            r_lvl      <= r_s2;
            r_stab_cnt <= '0;
        end else begin
            r_stab_cnt <= r_stab_cnt + SW'(1);
        end
    end

    // Bit phase: hard resync on every accepted edge, else free-run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (w_lvl_chg || (r_phase == PH_LAST)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Count whole bit periods since the last accepted edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_cnt <= '0;
        end else if (w_lvl_chg) begin
            r_run_cnt <= '0;
        end else if (w_wrap && (r_run_cnt != RUN_MAX)) begin
            r_run_cnt <= r_run_cnt + RW'(1);
        end
    end

    // Sample the filtered level at mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= (r_phase == PH_HALF);
            if (r_phase == PH_HALF) begin
                r_bit_out <= r_lvl;
            end
        end
    end

    // Hunt for the sync word, then assemble a fixed-length frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_HUNT;
            r_sr         <= '0;
            r_acc        <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (r_bit_valid) begin
                        r_sr <= w_sr_next[6:0];
                        if (w_sr_next == SYNC_WORD) begin
                            r_state    <= ST_LOCK;
                            r_acc      <= '0;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_timeout && !w_last_byte) begin
                        r_state     <= ST_HUNT;
                        r_sr        <= '0;
                        r_acc       <= '0;
                        r_bit_cnt   <= '0;
                        r_byte_cnt  <= '0;
                        r_frame_err <= 1'b1;
                    end else if (r_bit_valid) begin
                        r_acc     <= w_acc_next[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            r_byte_out   <= w_acc_next;
                            r_byte_valid <= 1'b1;
                            if (w_last_byte) begin
                                r_state    <= ST_HUNT;
                                r_sr       <= '0;
                                r_byte_cnt <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + BCW'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_bit_sync.sv
// tb_fsk_bit_sync: drives waveform segments into fsk_bit_sync and
// compares every cycle against an arithmetic reference model.
module tb_fsk_bit_sync;

    localparam int         BL   = 16;
    localparam int         FI   = 4;
    localparam int         FB   = 2;
    localparam int         MR   = 16;
    localparam logic [7:0] SYN  = 8'hA5;
    localparam int         MAXT = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fsk_demod = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       locked;
    logic       frame_err;

    fsk_bit_sync #(
        .BIT_LEN(BL), .FILT(FI), .SYNC_WORD(SYN),
        .FRAME_BYTES(FB), .MAX_RUN(MR)
    ) dut (
        .clk(clk), .reset(reset), .fsk_demod(fsk_demod),
        .bit_out(bit_out), .bit_valid(bit_valid),
        .byte_out(byte_out), .byte_valid(byte_valid),
        .locked(locked), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    bit wav[$];
    int want_q[$];

    bit e_bv  [MAXT];
    bit e_bo  [MAXT];
    bit e_byv [MAXT];
    int e_byo [MAXT];
    bit e_lk  [MAXT];
    bit e_fe  [MAXT];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)",
                      tag, got, exp, $time);
    endtask

    function automatic bit dget(input int i);
        if (i < 0 || i >= wav.size()) return 1'b0;
        return wav[i];
    endfunction

    task automatic put(input bit v, input int n);
        repeat (n) wav.push_back(v);
    endtask

    task automatic put_byte(input logic [7:0] v, input int nb,
                            input bit noisy);
        for (int i = nb - 1; i >= 0; i--) begin
            bit b;
            int len, g, pos;
            b = v[i];
            len = noisy ? (BL - 1 + int'($urandom_range(2))) : BL;
            if (noisy && $urandom_range(3) == 0) begin
                g = $urandom_range(FI - 1, 1);
                pos = $urandom_range(len - g - 3, 3);
                put(b, pos);
                put(!b, g);
                put(b, len - pos - g);
            end else begin
                put(b, len);
            end
        end
    endtask

    // Reference: level from a FILT-sample window of the two-clock
    // delayed input, phase and run length from the last edge time,
    // framing from the list of recovered bits.
    task automatic build_model(input int T);
        bit lv;
        bit lk;
        int c, sr, acc, nb, nby, byo;
        lv = 0; lk = 0; c = -1;
        sr = 0; acc = 0; nb = 0; nby = 0; byo = 0;
        for (int k = 0; k < T; k++) begin
            int ph, rn;
            bit all, ev, b, tmo, fin, byv, fe;
            ph  = (k - 1 - c) % BL;
            rn  = (k - 1 - c) / BL;
            if (rn > MR) rn = MR;
            ev  = (k > 0) && e_bv[k-1];
            b   = (k > 0) ? e_bo[k-1] : 1'b0;
            tmo = lk && (rn == MR);
            e_bv[k] = (ph == BL / 2);
            e_bo[k] = lv;
            all = 1;
            for (int j = k - 1 - FI; j <= k - 2; j++)
                if (dget(j) == lv) all = 0;
            if (all) begin
                lv = !lv;
                c = k;
            end
            byv = 0;
            fe = 0;
            if (!lk) begin
                if (ev) begin
                    sr = ((sr << 1) | int'(b)) & 255;
                    if (sr == int'(SYN)) begin
                        lk = 1; acc = 0; nb = 0; nby = 0;
                    end
                end
            end else begin
                fin = ev && (nb == 7) && (nby == FB - 1);
                if (tmo && !fin) begin
                    lk = 0; sr = 0; acc = 0; nb = 0; nby = 0;
                    fe = 1;
                end else if (ev) begin
                    acc = ((acc << 1) | int'(b)) & 255;
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        byo = acc;
                        byv = 1;
                        nby++;
                        if (nby == FB) begin
                            lk = 0; sr = 0; nby = 0;
                        end
                    end
                end
            end
            e_byv[k] = byv;
            e_byo[k] = byo;
            e_lk[k]  = lk;
            e_fe[k]  = fe;
        end
    endtask

    function automatic int outs();
        return int'({bit_out, bit_valid, byte_out,
                     byte_valid, locked, frame_err});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_now", outs(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", outs(), 0);
            fsk_demod = ~fsk_demod;
        end
    endtask

    task automatic run_seg(input string name, input int lat_exp,
                           input bit use_want, input int want_fe,
                           input bit want_lk_end);
        int T, fe_cnt, first_one;
        int got_b[$];
        T = wav.size();
        if (T > MAXT) begin
            $display("FAIL %s.length: got %0d, want <= %0d",
                     name, T, MAXT);
            $fatal(1);
        end
        build_model(T);
        do_reset();
        fe_cnt = 0;
        first_one = -1;
        @(negedge clk);
        fsk_demod = wav[0];
        reset = 1'b1;
        for (int k = 0; k < T; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, ".bit_valid"}, bit_valid, e_bv[k]);
            if (e_bv[k]) chk({name, ".bit_out"}, bit_out, e_bo[k]);
            chk({name, ".byte_valid"}, byte_valid, e_byv[k]);
            chk({name, ".byte_out"}, byte_out, e_byo[k]);
            chk({name, ".locked"}, locked, e_lk[k]);
            chk({name, ".frame_err"}, frame_err, e_fe[k]);
            chk({name, ".strobe_excl"}, bit_valid & byte_valid, 0);
            if (byte_valid) got_b.push_back(int'(byte_out));
            if (frame_err) fe_cnt++;
            if (first_one < 0 && bit_valid && bit_out) first_one = k;
            if (k + 1 < T) fsk_demod = wav[k+1];
        end
        if (lat_exp >= 0) chk({name, ".latency"}, first_one, lat_exp);
        if (want_fe >= 0) chk({name, ".n_frame_err"}, fe_cnt, want_fe);
        if (use_want) begin
            chk({name, ".n_bytes"}, got_b.size(), want_q.size());
            for (int i = 0; i < want_q.size() && i < got_b.size(); i++)
                chk({name, ".byte"}, got_b[i], want_q[i]);
        end
        if (want_lk_end) chk({name, ".lock_end"}, locked, 1);
        wav.delete();
        want_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        // Latency, sub-FILT glitch and an exactly-FILT pulse.
        put(0, 40);
        put(1, BL * 2 + 5);
        put(0, FI - 1);
        put(1, BL * 3);
        put(0, FI);
        put(1, BL * 3);
        run_seg("latency", 40 + 2 + FI + BL / 2, 0, 0, 0);

        put_byte(8'h00, 2, 0);
        put_byte(SYN, 8, 0);
        put_byte(8'h3C, 8, 0);
        put_byte(8'hC3, 8, 0);
        put(0, BL * 4);
        want_q = '{8'h3C, 8'hC3};
        run_seg("frame", -1, 1, 0, 0);

        put_byte(8'h00, 2, 0);
        put_byte(8'hA4, 8, 0);
        put_byte(8'h4B, 8, 0);
        put_byte(8'h03, 3, 0);
        put_byte(SYN, 8, 0);
        put_byte(8'h12, 8, 0);
        put_byte(8'h34, 8, 0);
        put(0, BL * 4);
        want_q = '{8'h12, 8'h34};
        run_seg("false_sync", -1, 1, 0, 0);

        put_byte(8'h00, 2, 0);
        put_byte(SYN, 8, 0);
        put_byte(8'h3C, 8, 0);
        put(0, BL * 17);
        run_seg("hold_low", -1, 0, -1, 0);

        put_byte(8'h00, 2, 0);
        put_byte(SYN, 8, 0);
        put(1, BL * 20);
        want_q = '{8'hFF};
        run_seg("timeout", -1, 1, 1, 0);

        put_byte(8'h00, 2, 0);
        put_byte(SYN, 8, 0);
        put_byte(SYN, 8, 0);
        put_byte(SYN, 8, 0);
        put_byte(SYN, 8, 0);
        put_byte(8'h5A, 8, 0);
        put_byte(8'h0F, 8, 0);
        put(0, BL * 4);
        want_q = '{8'hA5, 8'hA5, 8'h5A, 8'h0F};
        run_seg("sync_payload", -1, 1, 0, 0);

        put_byte(8'h00, 2, 0);
        put_byte(SYN, 8, 0);
        put_byte(8'h3C, 8, 0);
        put_byte(8'hA0, 4, 0);
        run_seg("midframe", -1, 0, 0, 1);

        for (int s = 0; s < 6; s++) begin
            int nby;
            put(0, $urandom_range(BL * 3, 5));
            if ($urandom_range(1) == 0) put_byte(SYN, 8, 1);
            nby = $urandom_range(5, 1);
            for (int i = 0; i < nby; i++) begin
                logic [7:0] v;
                case ($urandom_range(3))
                    0: v = SYN;
                    1: v = 8'hFF;
                    default: v = 8'($urandom);
                endcase
                put_byte(v, 8, 1);
                if ($urandom_range(3) == 0)
                    put(1'($urandom_range(1)), BL * $urandom_range(18, 4));
            end
            put(0, BL * 2);
            run_seg("random", -1, 0, -1, 0);
        end

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
